// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared state encoding, forward-select constants and control
//            bundle for the pipeline controller, DBUFF and datapath muxes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_REDIR   = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic pc_we;
    logic fbuff_stall;
    logic fbuff_flush;
    logic dbuff_stall;
    logic dbuff_flush;
  } ctrl_t;

  // Priority resolution used by RUN and by MEMWAIT once memory is ready.
  function automatic ctrl_t run_ctrl(input logic mem_busy, input logic br_taken,
                                     input logic hazard);
    ctrl_t c;
    c = '{pc_we: 1'b1, default: 1'b0};
    if (mem_busy) begin
      c.pc_we       = 1'b0;
      c.fbuff_stall = 1'b1;
      c.dbuff_stall = 1'b1;
    end else if (br_taken) begin
      c.fbuff_flush = 1'b1;
      c.dbuff_flush = 1'b1;
    end else if (hazard) begin
      c.pc_we       = 1'b0;
      c.fbuff_stall = 1'b1;
      c.dbuff_flush = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [1:0] run_next(input logic mem_busy, input logic br_taken);
    if (mem_busy) return ST_MEMWAIT;
    if (br_taken) return ST_REDIR;
    return ST_RUN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_fwd.sv
// ============================================================================
// Module   : pipe_fwd_unit
// Purpose  : Forward-source select for one decode operand; EX beats MEM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_src,
  input  logic       i_used,
  input  logic [3:0] i_ex_dst,
  input  logic       i_ex_regwr,
  input  logic       i_ex_is_lw,
  input  logic [3:0] i_mem_dst,
  input  logic       i_mem_regwr,
  output logic [1:0] o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  // A load in EX has no result yet; that case is covered by the load-use stall.
  assign w_ex_hit  = i_ex_regwr & ~i_ex_is_lw & (i_ex_dst == i_src);
  assign w_mem_hit = i_mem_regwr & (i_mem_dst == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (i_used) begin
      if (w_ex_hit)       o_sel = FWD_EX;
      else if (w_mem_hit) o_sel = FWD_MEM;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline hazard controller: stall/flush FSM, forwarding selects
//            and saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dec_src1,
  input  logic [3:0]  dec_src2,
  input  logic        dec_src1_used,
  input  logic        dec_src2_used,
  input  logic [3:0]  ex_dst,
  input  logic        ex_regwr,
  input  logic        ex_is_lw,
  input  logic [3:0]  mem_dst,
  input  logic        mem_regwr,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        fbuff_stall,
  output logic        fbuff_flush,
  output logic        dbuff_stall,
  output logic        dbuff_flush,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        w_hazard;
  ctrl_t       w_ctrl;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  assign w_hazard = ex_is_lw & ex_regwr &
                    ((dec_src1_used & (dec_src1 == ex_dst)) |
                     (dec_src2_used & (dec_src2 == ex_dst)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = ST_RUN;
    case (r_state)
      ST_RUN, ST_MEMWAIT: w_next_state = run_next(mem_busy, br_taken);
      ST_REDIR:           w_next_state = mem_busy ? ST_MEMWAIT : ST_RUN;
      default:            w_next_state = ST_RUN;
    endcase
  end

  // REDIR keeps squashing the fetch buffer while the new-target fetch lands.
  always_comb begin
    w_ctrl = run_ctrl(mem_busy, br_taken, w_hazard);
    if (r_state == ST_REDIR) begin
      w_ctrl             = '{default: 1'b0};
      w_ctrl.fbuff_flush = 1'b1;
      w_ctrl.pc_we       = ~mem_busy;
      w_ctrl.dbuff_stall = mem_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (!w_ctrl.pc_we && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if ((w_ctrl.fbuff_flush || w_ctrl.dbuff_flush) && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  pipe_fwd_unit u_fwd1 (
    .i_src       (dec_src1),
    .i_used      (dec_src1_used),
    .i_ex_dst    (ex_dst),
    .i_ex_regwr  (ex_regwr),
    .i_ex_is_lw  (ex_is_lw),
    .i_mem_dst   (mem_dst),
    .i_mem_regwr (mem_regwr),
    .o_sel       (fwd1_sel)
  );

  pipe_fwd_unit u_fwd2 (
    .i_src       (dec_src2),
    .i_used      (dec_src2_used),
    .i_ex_dst    (ex_dst),
    .i_ex_regwr  (ex_regwr),
    .i_ex_is_lw  (ex_is_lw),
    .i_mem_dst   (mem_dst),
    .i_mem_regwr (mem_regwr),
    .o_sel       (fwd2_sel)
  );

  assign pc_we       = w_ctrl.pc_we;
  assign fbuff_stall = w_ctrl.fbuff_stall;
  assign fbuff_flush = w_ctrl.fbuff_flush;
  assign dbuff_stall = w_ctrl.dbuff_stall;
  assign dbuff_flush = w_ctrl.dbuff_flush;
  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dec_src1, dec_src2, ex_dst, mem_dst;
  logic        dec_src1_used, dec_src2_used, ex_regwr, ex_is_lw, mem_regwr;
  logic        br_taken, mem_busy;
  logic        pc_we, fbuff_stall, fbuff_flush, dbuff_stall, dbuff_flush;
  logic [1:0]  fwd1_sel, fwd2_sel, state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pipeline mode (0 running, 1 waiting on memory,
  // 2 one-cycle redirect shadow) and plain integer counters.
  int m_state = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dec_src1      (dec_src1),
    .dec_src2      (dec_src2),
    .dec_src1_used (dec_src1_used),
    .dec_src2_used (dec_src2_used),
    .ex_dst        (ex_dst),
    .ex_regwr      (ex_regwr),
    .ex_is_lw      (ex_is_lw),
    .mem_dst       (mem_dst),
    .mem_regwr     (mem_regwr),
    .br_taken      (br_taken),
    .mem_busy      (mem_busy),
    .pc_we         (pc_we),
    .fbuff_stall   (fbuff_stall),
    .fbuff_flush   (fbuff_flush),
    .dbuff_stall   (dbuff_stall),
    .dbuff_flush   (dbuff_flush),
    .fwd1_sel      (fwd1_sel),
    .fwd2_sel      (fwd2_sel),
    .state         (state),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int fwd_exp(input logic [3:0] src, input logic used);
    if (!used) return 0;
    if (ex_regwr && !ex_is_lw && ex_dst == src) return 1;
    if (mem_regwr && mem_dst == src) return 2;
    return 0;
  endfunction

  task automatic step(input bit do_chk);
    bit haz;
    int e_pc, e_fs, e_ff, e_ds, e_df, nxt;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      m_state = 0; m_stall = 0; m_flush = 0;
    end
    haz = ex_is_lw && ex_regwr &&
          ((dec_src1_used && dec_src1 == ex_dst) || (dec_src2_used && dec_src2 == ex_dst));
    e_pc = 1; e_fs = 0; e_ff = 0; e_ds = 0; e_df = 0; nxt = 0;
    if (m_state == 2) begin
      e_ff = 1;
      if (mem_busy) begin e_pc = 0; e_ds = 1; nxt = 1; end
    end else if (mem_busy) begin
      e_pc = 0; e_fs = 1; e_ds = 1; nxt = 1;
    end else if (br_taken) begin
      e_ff = 1; e_df = 1; nxt = 2;
    end else if (haz) begin
      e_pc = 0; e_fs = 1; e_df = 1;
    end
    if (do_chk) begin
      chk("state", state, m_state);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
      chk("pc_we", pc_we, e_pc);
      chk("fbuff_stall", fbuff_stall, e_fs);
      chk("fbuff_flush", fbuff_flush, e_ff);
      chk("dbuff_stall", dbuff_stall, e_ds);
      chk("dbuff_flush", dbuff_flush, e_df);
      chk("fwd1_sel", fwd1_sel, fwd_exp(dec_src1, dec_src1_used));
      chk("fwd2_sel", fwd2_sel, fwd_exp(dec_src2, dec_src2_used));
    end
    @(posedge clk);
    if (rst_n) begin
      m_state = nxt;
      if (e_pc == 0) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (e_ff + e_df > 0) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
    end
    #1;
  endtask

  task automatic idle_inputs();
    dec_src1 = 4'd0; dec_src2 = 4'd0; dec_src1_used = 1'b0; dec_src2_used = 1'b0;
    ex_dst = 4'd0; ex_regwr = 1'b0; ex_is_lw = 1'b0;
    mem_dst = 4'd0; mem_regwr = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    int s0, f0;
    rst_n = 1'b0;
    idle_inputs();
    step(1);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Load-use hazard on src1
    ex_is_lw = 1'b1; ex_regwr = 1'b1; ex_dst = 4'd5; dec_src1 = 4'd5; dec_src1_used = 1'b1;
    s0 = m_stall;
    step(1);
    chk("lu_stall_inc", stall_cnt, s0 + 1);
    idle_inputs();
    step(1);

    // Branch pulse: flush, redirect shadow, back to run
    f0 = m_flush;
    br_taken = 1'b1;
    step(1);
    br_taken = 1'b0;
    step(1);
    step(1);
    chk("br_flush_inc", flush_cnt, f0 + 2);

    // Memory busy with branch held
    s0 = m_stall;
    br_taken = 1'b1; mem_busy = 1'b1;
    repeat (3) step(1);
    mem_busy = 1'b0;
    step(1);
    chk("mb_stall_inc", stall_cnt, s0 + 3);
    br_taken = 1'b0;
    step(1);

    // Forward priority on src2
    ex_dst = 4'd7; mem_dst = 4'd7; ex_regwr = 1'b1; mem_regwr = 1'b1; ex_is_lw = 1'b0;
    dec_src2 = 4'd7; dec_src2_used = 1'b1;
    #1 chk("fwd2_ex", fwd2_sel, 1);
    ex_regwr = 1'b0;
    #1 chk("fwd2_mem", fwd2_sel, 2);
    dec_src2_used = 1'b0;
    #1 chk("fwd2_unused", fwd2_sel, 0);
    idle_inputs();
    step(1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      dec_src1 = 4'($urandom_range(0, 3)); dec_src2 = 4'($urandom_range(0, 3));
      dec_src1_used = 1'($urandom); dec_src2_used = 1'($urandom);
      ex_dst = 4'($urandom_range(0, 3)); ex_regwr = 1'($urandom); ex_is_lw = 1'($urandom);
      mem_dst = 4'($urandom_range(0, 3)); mem_regwr = 1'($urandom);
      br_taken = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      step(1);
    end

    // Reset mid-MEMWAIT, between edges
    idle_inputs();
    mem_busy = 1'b1;
    step(1);
    chk("in_memwait", state, 1);
    rst_n = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    step(1);
    mem_busy = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("post_rst_pc_we", pc_we, 1);

    // Stall counter saturation
    mem_busy = 1'b1;
    repeat (70000) step(0);
    step(1);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    mem_busy = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
